// File: rtl/dmem_port_arb.sv
// Purpose : round-robin arbiter/sequencer sharing one d_mem line port between two CPUs.
// Latency : request at edge N -> grant/strobe from N+1; mem_rdy at edge M -> done in cycle M+1, IDLE at M+2.
// Backpressure: strobes held until mem_rdy; losing CPU waits with its request level high.
// Optional: define DMEM_ARB_TIMEOUT_EN to abort a BUSY phase after TIMEOUT cycles (done_x + err_x).
module dmem_port_arb #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        u_re_0,
   input  logic        u_we_0,
   input  logic [10:0] u_addr_0,
   input  logic [63:0] d_line_0,
   input  logic        u_re_1,
   input  logic        u_we_1,
   input  logic [10:0] u_addr_1,
   input  logic [63:0] d_line_1,
   output logic        grant_0,
   output logic        grant_1,
   output logic        done_0,
   output logic        done_1,
   output logic        err_0,
   output logic        err_1,
   output logic [63:0] u_rd_data,
   output logic        busy,
   output logic [10:0] mem_addr,
   output logic        mem_re,
   output logic        mem_we,
   output logic [63:0] mem_wdata,
   input  logic        mem_rdy,
   input  logic [63:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   logic        last;      // CPU that owned the most recent completed transaction
   logic        win;       // CPU owning the transaction in flight
   logic        op_we;     // transaction is a write
   logic        req_0;
   logic        req_1;
   logic        sel;
   logic [10:0] sel_addr;
   logic [63:0] sel_line;
   logic        sel_we;

   // Reject out-of-range timeout settings at elaboration.
   generate
      if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
         $error("dmem_port_arb: TIMEOUT must be in 2..255");
      end
   endgenerate

`ifdef DMEM_ARB_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
   logic [7:0] cnt;
`else
   assign err_0 = 1'b0;
   assign err_1 = 1'b0;
`endif

   assign req_0 = u_re_0 | u_we_0;
   assign req_1 = u_re_1 | u_we_1;

   // Pick the winner: sole requester wins, a tie goes to the CPU that was not served last.
   always_comb begin
      sel = 1'b0;
      if (req_0 && req_1) begin
         sel = ~last;
      end else if (req_1) begin
         sel = 1'b1;
      end
      sel_addr = sel ? u_addr_1 : u_addr_0;
      sel_line = sel ? d_line_1 : d_line_0;
      // Write wins when both strobes are high, so the op is just the write strobe.
      sel_we   = sel ? u_we_1 : u_we_0;
   end

   // Transaction FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last      <= 1'b1;
         win       <= 1'b0;
         op_we     <= 1'b0;
         grant_0   <= 1'b0;
         grant_1   <= 1'b0;
         done_0    <= 1'b0;
         done_1    <= 1'b0;
         busy      <= 1'b0;
         mem_re    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         u_rd_data <= '0;
`ifdef DMEM_ARB_TIMEOUT_EN
         err_0     <= 1'b0;
         err_1     <= 1'b0;
         cnt       <= '0;
`endif
      end else begin
         done_0 <= 1'b0;
         done_1 <= 1'b0;
`ifdef DMEM_ARB_TIMEOUT_EN
         err_0  <= 1'b0;
         err_1  <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (req_0 || req_1) begin
                  win       <= sel;
                  op_we     <= sel_we;
                  grant_0   <= ~sel;
                  grant_1   <= sel;
                  busy      <= 1'b1;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_line;
                  mem_re    <= ~sel_we;
                  mem_we    <= sel_we;
`ifdef DMEM_ARB_TIMEOUT_EN
                  cnt       <= '0;
`endif
                  state     <= BUSY;
               end
            end
            BUSY: begin
               // mem_rdy takes priority over a timeout on the same cycle.
               if (mem_rdy) begin
                  mem_re <= 1'b0;
                  mem_we <= 1'b0;
                  if (!op_we) begin
                     u_rd_data <= mem_rdata;
                  end
                  done_0 <= ~win;
                  done_1 <= win;
                  last   <= win;
                  state  <= DONE;
               end
`ifdef DMEM_ARB_TIMEOUT_EN
               else if (cnt == TO_LAST) begin
                  mem_re    <= 1'b0;
                  mem_we    <= 1'b0;
                  u_rd_data <= '0;
                  done_0    <= ~win;
                  done_1    <= win;
                  err_0     <= ~win;
                  err_1     <= win;
                  last      <= win;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
`endif
            end
            DONE: begin
               grant_0 <= 1'b0;
               grant_1 <= 1'b0;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               grant_0 <= 1'b0;
               grant_1 <= 1'b0;
               busy    <= 1'b0;
               mem_re  <= 1'b0;
               mem_we  <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   // Structural invariants of the port.
   a_grant_onehot : assert property (@(posedge clk) disable iff (!rst_n) !(grant_0 && grant_1));
   a_strobe_excl  : assert property (@(posedge clk) disable iff (!rst_n) !(mem_re && mem_we));
   a_strobe_busy  : assert property (@(posedge clk) disable iff (!rst_n) (mem_re || mem_we) |-> (state == BUSY));
   a_done0_grant  : assert property (@(posedge clk) disable iff (!rst_n) done_0 |-> grant_0);
   a_done1_grant  : assert property (@(posedge clk) disable iff (!rst_n) done_1 |-> grant_1);
   a_busy_state   : assert property (@(posedge clk) disable iff (!rst_n) busy == (state != IDLE));

endmodule

// File: tb/tb_dmem_port_arb.sv
// Directed bench for dmem_port_arb: reset, single read, write precedence, round-robin,
// mid-transaction input changes, async reset abort, and BUSY timeout / no-timeout behaviour.
// Inputs change 1 ns after the rising edge; outputs are checked at that same point.
module tb_dmem_port_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        u_re_0, u_we_0, u_re_1, u_we_1;
   logic [10:0] u_addr_0, u_addr_1;
   logic [63:0] d_line_0, d_line_1;
   logic        grant_0, grant_1, done_0, done_1, err_0, err_1;
   logic [63:0] u_rd_data;
   logic        busy;
   logic [10:0] mem_addr;
   logic        mem_re, mem_we;
   logic [63:0] mem_wdata;
   logic        mem_rdy;
   logic [63:0] mem_rdata;

   int   n_tests = 0;
   int   n_fail  = 0;
   logic g1_seen = 1'b0;

   always #5 clk = ~clk;

   dmem_port_arb #(.TIMEOUT(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .u_re_0    (u_re_0),
      .u_we_0    (u_we_0),
      .u_addr_0  (u_addr_0),
      .d_line_0  (d_line_0),
      .u_re_1    (u_re_1),
      .u_we_1    (u_we_1),
      .u_addr_1  (u_addr_1),
      .d_line_1  (d_line_1),
      .grant_0   (grant_0),
      .grant_1   (grant_1),
      .done_0    (done_0),
      .done_1    (done_1),
      .err_0     (err_0),
      .err_1     (err_1),
      .u_rd_data (u_rd_data),
      .busy      (busy),
      .mem_addr  (mem_addr),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdy   (mem_rdy),
      .mem_rdata (mem_rdata)
   );

   // Advance one clock; track whether grant_1 was ever seen high.
   task automatic step();
      @(posedge clk);
      #1;
      g1_seen = g1_seen | grant_1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      u_re_0 = 0; u_we_0 = 0; u_addr_0 = '0; d_line_0 = '0;
      u_re_1 = 0; u_we_1 = 0; u_addr_1 = '0; d_line_1 = '0;
      mem_rdy = 0; mem_rdata = '0;

      // ---------------- reset state ----------------
      #12;
      check("rst_grant0", grant_0, 0);
      check("rst_grant1", grant_1, 0);
      check("rst_busy", busy, 0);
      check("rst_mem_re", mem_re, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_done", {done_0, done_1}, 0);
      check("rst_err", {err_0, err_1}, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_rd_data", u_rd_data, 0);
      step();
      rst_n = 1'b1;
      step();
      g1_seen = 1'b0;

      // ---------------- single read, CPU0 ----------------
      u_re_0 = 1; u_addr_0 = 11'h123;
      step();
      check("rd_grant0", grant_0, 1);
      check("rd_mem_re", mem_re, 1);
      check("rd_mem_we", mem_we, 0);
      check("rd_mem_addr", mem_addr, 11'h123);
      check("rd_busy", busy, 1);
      step();
      step();
      check("rd_wait_done", done_0, 0);
      check("rd_wait_re", mem_re, 1);
      mem_rdy = 1; mem_rdata = 64'hDEAD_BEEF_0123_4567;
      step();
      check("rd_done0", done_0, 1);
      check("rd_data", u_rd_data, 64'hDEAD_BEEF_0123_4567);
      check("rd_grant_in_done", grant_0, 1);
      check("rd_re_dropped", mem_re, 0);
      mem_rdy = 0; u_re_0 = 0;
      step();
      check("rd_done_pulse", done_0, 0);
      check("rd_grant_clear", grant_0, 0);
      check("rd_idle", busy, 0);
      check("rd_no_grant1", g1_seen, 0);

      // ---------------- write precedence, CPU1 ----------------
      u_re_1 = 1; u_we_1 = 1; u_addr_1 = 11'h7FF; d_line_1 = 64'hA5A5;
      step();
      check("wr_grant1", grant_1, 1);
      check("wr_mem_we", mem_we, 1);
      check("wr_mem_re", mem_re, 0);
      check("wr_wdata", mem_wdata, 64'hA5A5);
      check("wr_addr", mem_addr, 11'h7FF);
      mem_rdy = 1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      check("wr_done1", done_1, 1);
      check("wr_rd_unchanged", u_rd_data, 64'hDEAD_BEEF_0123_4567);
      mem_rdy = 0; u_re_1 = 0; u_we_1 = 0;
      step();
      check("wr_idle", busy, 0);

      // ---------------- simultaneous requests after reset ----------------
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      check("rr_rst_rd_data", u_rd_data, 0);
      u_re_0 = 1; u_addr_0 = 11'h010;
      u_re_1 = 1; u_addr_1 = 11'h020;
      mem_rdy = 1; mem_rdata = 64'h1111;
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("rr%0d_grant0", k), grant_0, (k % 2 == 0) ? 1 : 0);
         check($sformatf("rr%0d_grant1", k), grant_1, (k % 2 == 0) ? 0 : 1);
         check($sformatf("rr%0d_addr", k), mem_addr, (k % 2 == 0) ? 11'h010 : 11'h020);
         step();
         check($sformatf("rr%0d_done", k), {done_0, done_1}, (k % 2 == 0) ? 2'b10 : 2'b01);
         step();
         check($sformatf("rr%0d_idle", k), busy, 0);
      end
      u_re_0 = 0; u_re_1 = 0; mem_rdy = 0;
      step();
      check("rr_stay_idle", busy, 0);

      // ---------------- mid-transaction input change ----------------
      u_re_0 = 1; u_addr_0 = 11'h055;
      step();
      check("mid_grant0", grant_0, 1);
      check("mid_addr", mem_addr, 11'h055);
      u_addr_0 = 11'h3AA; u_re_0 = 0;
      step();
      check("mid_addr_held", mem_addr, 11'h055);
      check("mid_re_held", mem_re, 1);
      step();
      mem_rdy = 1; mem_rdata = 64'h0BAD;
      step();
      check("mid_done0", done_0, 1);
      check("mid_addr_done", mem_addr, 11'h055);
      check("mid_rd_data", u_rd_data, 64'h0BAD);
      mem_rdy = 0;
      step();
      check("mid_idle", busy, 0);
      check("mid_addr_idle_hold", mem_addr, 11'h055);

      // ---------------- reset during BUSY ----------------
      u_re_0 = 1; u_addr_0 = 11'h0AA;
      step();
      check("rb_mem_re", mem_re, 1);
      rst_n = 1'b0;
      #1;
      check("rb_re_async", mem_re, 0);
      check("rb_grant_async", grant_0, 0);
      check("rb_busy_async", busy, 0);
      u_re_0 = 0;
      step();
      rst_n = 1'b1;
      u_re_1 = 1; u_addr_1 = 11'h111;
      step();
      check("rb_grant1", grant_1, 1);
      check("rb_grant0", grant_0, 0);
      check("rb_addr", mem_addr, 11'h111);
      check("rb_re", mem_re, 1);
      mem_rdy = 1; mem_rdata = 64'h2222;
      step();
      check("rb_done", {done_0, done_1}, 2'b01);
      check("rb_rd_data", u_rd_data, 64'h2222);
      mem_rdy = 0; u_re_1 = 0;
      step();
      check("rb_idle", busy, 0);

      // ---------------- stalled memory ----------------
      u_re_0 = 1; u_addr_0 = 11'h0F0;
      step();
      check("to_busy", busy, 1);
      u_re_0 = 0;
`ifdef DMEM_ARB_TIMEOUT_EN
      for (int i = 0; i < 7; i++) step();
      check("to_not_yet", done_0, 0);
      check("to_still_re", mem_re, 1);
      step();
      check("to_done0", done_0, 1);
      check("to_err0", err_0, 1);
      check("to_rd_zero", u_rd_data, 0);
      check("to_re_drop", mem_re, 0);
      step();
      check("to_err_pulse", err_0, 0);
      check("to_idle", busy, 0);
`else
      for (int i = 0; i < 20; i++) step();
      check("nto_busy", busy, 1);
      check("nto_re", mem_re, 1);
      check("nto_done", done_0, 0);
      check("nto_err", err_0, 0);
      mem_rdy = 1; mem_rdata = 64'h3333;
      step();
      check("nto_done0", done_0, 1);
      check("nto_err_done", err_0, 0);
      check("nto_rd_data", u_rd_data, 64'h3333);
      mem_rdy = 0;
      step();
      check("nto_idle", busy, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_port_arb.md
# dmem_port_arb

Two-requester arbiter and sequencer for the single shared data-memory line port. It sits between the two CPU cache-fill/writeback interfaces (line address, read/write strobes, 64-bit line) and the one `d_mem` instance. It grants the port to exactly one CPU at a time, round-robin. It holds the memory strobes until `d_mem` reports ready, then returns the read line and a one-cycle completion pulse to the granted CPU.

## Interface
Parameters:
- `TIMEOUT`, 64: maximum BUSY cycles before abort; only used with `DMEM_ARB_TIMEOUT_EN`. Legal range 2..255.

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `rst_n` in 1: asynchronous active-low reset.
- `u_re_0`, `u_we_0` in 1 each: CPU0 line read / write request (level).
- `u_addr_0` in 11: CPU0 line address.
- `d_line_0` in 64: CPU0 write line.
- `u_re_1`, `u_we_1`, `u_addr_1`, `d_line_1`: same signals for CPU1.
- `grant_0`, `grant_1` out 1 each: port owner, one-hot or zero.
- `done_0`, `done_1` out 1 each: one-cycle transaction-complete pulse.
- `err_0`, `err_1` out 1 each: one-cycle timeout-abort pulse, coincident with `done_x`.
- `u_rd_data` out 64: registered read line, valid while `done_x` is high.
- `busy` out 1: high in any state other than IDLE.
- `mem_addr` out 11: to `d_mem`.
- `mem_re`, `mem_we` out 1 each: to `d_mem`.
- `mem_wdata` out 64: to `d_mem`.
- `mem_rdy` in 1: from `d_mem`.
- `mem_rdata` in 64: from `d_mem`.

## Operation
- Request `req_x = u_re_x | u_we_x`. If both strobes are high, the transaction is a write; `u_re_x` is ignored for that transaction.
- FSM states: IDLE, BUSY, DONE.
- IDLE, no request: remain in IDLE.
- IDLE, any request:
  - Select the winner. A sole requester wins. If both request, the CPU other than `last` wins.
  - Latch the winner's address, line and op into the transaction registers.
  - Set `grant_x`, then go to BUSY.
- BUSY:
  - `mem_addr` and `mem_wdata` are driven from the transaction registers.
  - Exactly one of `mem_re` / `mem_we` is high, held until `mem_rdy` is sampled high.
  - On `mem_rdy`: for a read, capture `mem_rdata` into `u_rd_data`; for a write, `u_rd_data` is unchanged. Go to DONE.
- DONE:
  - `done_x` is high for one cycle; `grant_x` stays high.
  - `last` updates to the winner.
  - Next state is IDLE; `grant_x` clears on entry to IDLE.
- Requester rule: drop `req_x` no later than the cycle after `done_x`. A request still high in IDLE is treated as a new transaction.
- A request dropped during BUSY is ignored; the transaction completes normally.
- Request inputs and address changes during BUSY/DONE do not affect `mem_addr` or `mem_wdata`.
- Outside BUSY: `mem_re = mem_we = 0`; `mem_addr` and `mem_wdata` hold their last values.

## Timing
- Reset values:
  - FSM = IDLE; `grant_*`, `done_*`, `err_*`, `busy`, `mem_re`, `mem_we` = 0.
  - `mem_addr` = 0, `mem_wdata` = 0, `u_rd_data` = 0.
  - `last` = 1, so CPU0 wins the first tie.
- All outputs are registered.
- Latency: request sampled at edge N → `grant` and strobe high from N+1. If `mem_rdy` is first sampled at edge M ≥ N+1, `done` is high in cycle M+1 and IDLE is reached at M+2. Minimum request-to-done is 2 cycles.
- Back-to-back: the next grant can start 3 cycles after the previous grant began (IDLE is one cycle).
- Fairness: with both CPUs requesting continuously, grants alternate 0,1,0,1.
- A `mem_rdy` high while in IDLE or DONE is ignored.
- Asserting `rst_n` low mid-transaction aborts immediately: strobes and grants drop asynchronously and no `done` is issued.

## Configuration
- `DMEM_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on BUSY entry and increments each BUSY cycle.
  - If it reaches `TIMEOUT-1` without `mem_rdy`, go to DONE with `done_x` and `err_x` both high.
  - The strobe drops on the DONE entry and `u_rd_data` is forced to 0.
  - `mem_rdy` on the same cycle as the timeout wins: normal completion, no error.
- Not defined:
  - No counter; BUSY waits indefinitely.
  - `err_0` and `err_1` are tied to 0.

## Test plan
- Single read: CPU0 `u_re_0`=1, `u_addr_0`=11'h123; `mem_rdy` 3 cycles after `mem_re`, `mem_rdata`=64'hDEAD_BEEF_0123_4567 → `mem_addr`=11'h123, `done_0` high 1 cycle, `u_rd_data`=64'hDEAD_BEEF_0123_4567, `grant_1` never high.
- Write precedence: CPU1 `u_re_1`=`u_we_1`=1, `d_line_1`=64'hA5A5 → `mem_we`=1, `mem_re`=0, `mem_wdata`=64'hA5A5, `u_rd_data` unchanged.
- Simultaneous requests after reset: both request reads at the same edge → CPU0 granted first, CPU1 next; with continuous requests, 4 transactions grant 0,1,0,1.
- Mid-transaction change: CPU0 granted, `u_addr_0` changes and `u_re_0` drops during BUSY → `mem_addr` holds the original value and `done_0` still pulses.
- Reset during BUSY: `rst_n` low while `mem_re`=1 → `mem_re`, `grant_0`, `busy` = 0 immediately; after release, a new CPU1-only request is granted normally.
- Timeout (macro on, `TIMEOUT`=8): `mem_rdy` held 0 → `done_0` and `err_0` high 8 cycles after BUSY entry, `u_rd_data`=0. Macro off: the arbiter stays in BUSY and `err_0` stays 0.
